fft_demux_frame_sched: RTL and testbench
========================================

Name: fft_demux_frame_sched

Overview:
- Frame-level sequencer that distributes one serial FFT sample stream across NUM_LANES lane buffers.
- Counts samples within a frame and generates a registered one-hot lane select plus a row address and the data.
- Sits between the input sample interface and the per-lane FFT input RAMs.
- Owns the frame start/done handshake with the FFT control path.

Parameters:
- DATA_WIDTH, 8, sample width in bits.
- NUM_LANES, 16, number of output lanes. Power of two, 2..64.
- FRAME_LEN, 2048, samples per frame. Power of two and a multiple of NUM_LANES.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle frame start request. Accepted only in IDLE.
- s_valid  input  1  input sample valid.
- s_ready  output  1  input sample ready.
- s_data  input  DATA_WIDTH  input sample.
- s_last  input  1  upstream end-of-frame marker.
- m_ready  input  1  lane buffers can accept a write this cycle.
- lane_valid  output  1  lane write strobe.
- lane_sel  output  NUM_LANES  one-hot lane select.
- lane_row  output  clog2(FRAME_LEN/NUM_LANES)  row address within the selected lane.
- lane_data  output  DATA_WIDTH  registered sample.
- busy  output  1  high in RUN and DONE.
- frame_done  output  1  one-cycle pulse when a frame completes.
- len_err  output  1  one-cycle pulse when s_last disagrees with the sample count.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE. Sample counter cnt (clog2(FRAME_LEN) bits) = 0.
  - All outputs are 0, including s_ready, lane_valid, lane_sel, lane_row, lane_data, busy, frame_done and len_err.
  - Reset mid-frame discards the partial frame. No frame_done is issued.
- IDLE:
  - s_ready = 0.
  - start = 1 -> RUN next cycle, with cnt = 0.
  - s_valid is ignored.
- RUN:
  - s_ready = m_ready (combinational).
  - Accept occurs when s_valid & s_ready. On each accept:
    - cnt increments.
    - lane index = cnt[clog2(NUM_LANES)-1:0] (low bits, so samples are interleaved round-robin across lanes).
    - row = cnt >> clog2(NUM_LANES).
  - start is ignored in RUN.
- Output register: one cycle of latency from accept to lane outputs.
  - On accept at edge k: lane_valid = 1, lane_sel = 1 << lane_index, lane_row = row, lane_data = s_data, all visible after edge k.
  - In a non-accept cycle: lane_valid = 0 and lane_sel = 0. lane_row and lane_data hold their previous values.
  - lane_sel is always one-hot or zero.
- Frame termination, evaluated on the accepted sample:
  - cnt == FRAME_LEN-1 with s_last = 1: normal end. Go to DONE, cnt wraps to 0.
  - cnt == FRAME_LEN-1 with s_last = 0: go to DONE and pulse len_err with the transition.
  - cnt < FRAME_LEN-1 with s_last = 1: early termination. Pulse len_err, go to DONE, cnt = 0. The last sample is still written.
- DONE (exactly one cycle):
  - s_ready = 0.
  - frame_done = 1 during this cycle. It aligns with the cycle after the final lane write, i.e. the same cycle the final write's lane_valid is visible.
  - Next state is IDLE. A start arriving while in DONE is ignored.
- m_ready low in RUN: s_ready = 0 and no accept. Counter, state and output register (lane_valid = 0) hold. Stalls of any length are legal.
- busy = 1 in RUN and DONE.

Test Plan:
- Config NUM_LANES=16, FRAME_LEN=64. Reset, pulse start, stream 64 samples with data = index and m_ready = 1, s_last on sample 63.
  - Sample i is written to lane_sel bit (i%16), lane_row = i/16, data = i, one cycle after accept.
  - frame_done pulses once, the cycle after sample 63's accept. len_err never pulses. Return to IDLE.
- Same frame with m_ready toggled 1/0 every other cycle, plus a 10-cycle m_ready = 0 gap at sample 20.
  - s_ready tracks m_ready and no samples are lost or duplicated.
  - Lane/row mapping is identical to the previous scenario.
  - frame_done is delayed by exactly the total number of stall cycles.
- s_last asserted on sample 40.
  - len_err pulses once, the frame ends with 41 writes (last: lane 8, row 2), frame_done pulses.
  - The next start begins at lane 0, row 0.
- 64 samples with s_last never asserted.
  - len_err pulses once with the transition to DONE.
  - frame_done pulses. A 65th s_valid is not accepted (s_ready = 0).
- Assert rst asynchronously mid-cycle after sample 30.
  - All outputs go to 0 immediately and no frame_done is issued.
  - After release, start plus a full frame maps from lane 0, row 0.
- Pulse start during RUN and during DONE, and drive s_valid in IDLE.
  - All are ignored: no writes in IDLE, and the frame count is unaffected.

Source files
------------

// File: rtl/fft_demux_frame_sched.sv
// Frame sequencer: spreads one serial sample stream round-robin across NUM_LANES
// lane buffers, producing a registered one-hot lane select, row address and data.
module fft_demux_frame_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 16,
  parameter int FRAME_LEN  = 2048
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  input  logic                                   s_last,
  input  logic                                   m_ready,
  output logic                                   lane_valid,
  output logic [NUM_LANES-1:0]                   lane_sel,
  output logic [$clog2(FRAME_LEN/NUM_LANES)-1:0] lane_row,
  output logic [DATA_WIDTH-1:0]                  lane_data,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   len_err
);

  localparam int LOG_NL = $clog2(NUM_LANES);
  localparam int LOG_FL = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LOG_FL-1:0] cnt, cnt_nxt;
  logic              accept;
  logic              at_end;
  logic              err_nxt;

  assign accept = (state == RUN) & m_ready & s_valid;
  // FRAME_LEN is a power of two, so the final sample index is all ones.
  assign at_end = (cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_ready   = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        s_ready = m_ready;
        if (accept) begin
          cnt_nxt = cnt + 1'b1;
          // Either a full count or an upstream s_last ends the frame; disagreement is flagged.
          if (at_end || s_last) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
            err_nxt   = at_end ^ s_last;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_valid <= 1'b0;
      lane_sel   <= '0;
      lane_row   <= '0;
      lane_data  <= '0;
      len_err    <= 1'b0;
    end else begin
      lane_valid <= accept;
      lane_sel   <= accept ? (NUM_LANES'(1) << cnt[LOG_NL-1:0]) : '0;
      len_err    <= err_nxt;
      if (accept) begin
        lane_row  <= cnt[LOG_FL-1:LOG_NL];
        lane_data <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_fft_demux_frame_sched.sv
// Directed bench for fft_demux_frame_sched with 16 lanes and 64-sample frames.
module tb_fft_demux_frame_sched;

  localparam int DW = 8;
  localparam int NL = 16;
  localparam int FL = 64;
  localparam int RW = $clog2(FL / NL);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_ready = 1'b0;
  logic          lane_valid;
  logic [NL-1:0] lane_sel;
  logic [RW-1:0] lane_row;
  logic [DW-1:0] lane_data;
  logic          busy;
  logic          frame_done;
  logic          len_err;

  int checks = 0;
  int errors = 0;

  fft_demux_frame_sched #(
    .DATA_WIDTH(DW),
    .NUM_LANES (NL),
    .FRAME_LEN (FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_ready   (m_ready),
    .lane_valid(lane_valid),
    .lane_sel  (lane_sel),
    .lane_row  (lane_row),
    .lane_data (lane_data),
    .busy      (busy),
    .frame_done(frame_done),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"},    32'(s_ready),    0);
    chk({tag, "_lane_valid"}, 32'(lane_valid), 0);
    chk({tag, "_lane_sel"},   32'(lane_sel),   0);
    chk({tag, "_lane_row"},   32'(lane_row),   0);
    chk({tag, "_lane_data"},  32'(lane_data),  0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_len_err"},    32'(len_err),    0);
  endtask

  task automatic do_start();
    s_valid = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
  endtask

  // Streams n samples (data = index). m_ready is either held high or toggled with a
  // 10-cycle gap at sample 20. exp_cyc is the hand-computed edge count to the last accept.
  task automatic run_frame(input int n, input int last_idx, input bit toggle,
                           input bit exp_err, input bit expect_end, input bit poke,
                           input int exp_cyc);
    int i = 0;
    int cyc = 0;
    int gap = 0;
    bit gap_done = 1'b0;
    bit mr;
    while (i < n && cyc < 1000) begin
      if (toggle && i == 20 && !gap_done) begin
        gap = 10;
        gap_done = 1'b1;
      end
      if (gap > 0) begin
        mr = 1'b0;
        gap--;
      end else if (toggle) mr = (cyc % 2 == 0);
      else mr = 1'b1;
      m_ready = mr;
      s_valid = 1'b1;
      s_data  = DW'(i);
      s_last  = (i == last_idx);
      start   = poke && (i == 10);
      #1;
      chk("s_ready_run", 32'(s_ready), 32'(mr));
      @(posedge clk); #1;
      cyc++;
      if (mr) begin
        chk("lane_valid", 32'(lane_valid), 1);
        chk("lane_sel",   32'(lane_sel),   32'(1) << (i % NL));
        chk("lane_row",   32'(lane_row),   32'(i / NL));
        chk("lane_data",  32'(lane_data),  32'(i & 8'hff));
        i++;
      end else begin
        chk("stall_valid", 32'(lane_valid), 0);
        chk("stall_sel",   32'(lane_sel),   0);
      end
      if (i < n || !expect_end) begin
        chk("frame_done_run", 32'(frame_done), 0);
        chk("len_err_run",    32'(len_err),    0);
      end
    end
    start = 1'b0;
    if (cyc >= 1000) chk("timeout", 0, 1);
    if (!expect_end) return;
    chk("done_cycles",    32'(cyc),        32'(exp_cyc));
    chk("done_pulse",     32'(frame_done), 1);
    chk("done_len_err",   32'(len_err),    32'(exp_err));
    chk("done_busy",      32'(busy),       1);
    s_valid = 1'b1;
    s_last  = 1'b0;
    m_ready = 1'b1;
    s_data  = 8'hAA;
    start   = poke;
    #1;
    chk("done_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("idle_frame_done", 32'(frame_done), 0);
    chk("idle_len_err",    32'(len_err),    0);
    chk("idle_busy",       32'(busy),       0);
    chk("idle_valid",      32'(lane_valid), 0);
    chk("idle_s_ready",    32'(s_ready),    0);
    @(posedge clk); #1;
    chk("idle2_valid", 32'(lane_valid), 0);
    chk("idle2_busy",  32'(busy),       0);
    s_valid = 1'b0;
  endtask

  initial begin
    #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // s_valid in IDLE must be ignored
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data  = 8'h55;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle_ignore_valid", 32'(lane_valid), 0);
      chk("idle_ignore_busy",  32'(busy),       0);
      chk("idle_ignore_rdy",   32'(s_ready),    0);
    end
    s_valid = 1'b0;

    // Plain frame
    do_start();
    run_frame(64, 63, 1'b0, 1'b0, 1'b1, 1'b0, 64);

    // Toggled m_ready with a 10-cycle gap: 64 accepts + 73 stalls
    do_start();
    run_frame(64, 63, 1'b1, 1'b0, 1'b1, 1'b0, 137);

    // Early s_last on sample 40, then a clean frame from lane 0
    do_start();
    run_frame(41, 40, 1'b0, 1'b1, 1'b1, 1'b0, 41);
    do_start();
    run_frame(64, 63, 1'b0, 1'b0, 1'b1, 1'b0, 64);

    // s_last never asserted
    do_start();
    run_frame(64, -1, 1'b0, 1'b1, 1'b1, 1'b0, 64);

    // Asynchronous reset after sample 30
    do_start();
    run_frame(31, -1, 1'b0, 1'b0, 1'b0, 1'b0, 31);
    s_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_done", 32'(frame_done), 0);
    chk("post_rst_busy", 32'(busy),       0);
    @(posedge clk); #1;
    chk("post_rst_done2", 32'(frame_done), 0);
    do_start();
    run_frame(64, 63, 1'b0, 1'b0, 1'b1, 1'b0, 64);

    // start pulsed in RUN and DONE is ignored
    do_start();
    run_frame(64, 63, 1'b0, 1'b0, 1'b1, 1'b1, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
